// File: rtl/il_frame_ctrl.sv
// il_frame_ctrl: frame-sync and lane-sequencing controller for the Rx interleaver path.
// Searches the serial ADC stream for a sync word on the I lane, locks I/Q phase to it and
// emits aligned I/Q pairs with frame markers. A flywheel holds lock across missed syncs.
//
// Ports:
//   CLK_1        ADC sample clock, all logic on rising edge
//   RST          asynchronous active-low reset
//   START        level enable; low forces IDLE on the next edge
//   ADC_OUT      serial sample stream (I, Q alternating once aligned)
//   I_OUT/Q_OUT  current payload pair
//   IQ_VALID     one-cycle strobe when I_OUT/Q_OUT carry a new payload pair
//   FRAME_START  coincident with IQ_VALID of payload pair 0
//   LOCKED       high in PAYLOAD and SYNC
//   LOSS         one-cycle pulse when lock is dropped by the miss limit
//   STATE        IDLE=00, SEARCH=01, PAYLOAD=10, SYNC=11
module il_frame_ctrl #(
    parameter logic [7:0]  SYNC_WORD = 8'hE5,
    parameter int unsigned FRAME_LEN = 32,
    parameter int unsigned MISS_MAX  = 3
) (
    input  logic       CLK_1,
    input  logic       RST,
    input  logic       START,
    input  logic       ADC_OUT,
    output logic       I_OUT,
    output logic       Q_OUT,
    output logic       IQ_VALID,
    output logic       FRAME_START,
    output logic       LOCKED,
    output logic       LOSS,
    output logic [1:0] STATE
);

    typedef enum logic [1:0] {
        StIdle    = 2'b00,
        StSearch  = 2'b01,
        StPayload = 2'b10,
        StSync    = 2'b11
    } state_e;

    localparam logic [7:0] PcLast   = 8'(FRAME_LEN - 1);
    localparam logic [3:0] MissLim  = 4'(MISS_MAX);

    state_e      state_q, state_d;
    logic [14:0] sr_q, sr_d;
    logic        ph_q, ph_d;
    logic [7:0]  pc_q, pc_d;
    logic [3:0]  miss_q, miss_d;
    logic        temp_i_q, temp_i_d;
    logic        i_out_q, i_out_d;
    logic        q_out_q, q_out_d;
    logic        iq_valid_q, iq_valid_d;
    logic        frame_start_q, frame_start_d;
    logic        loss_q, loss_d;

    logic [15:0] win;
    logic [7:0]  i_lane;
    logic        match;
    logic [3:0]  miss_inc;

    // Odd window positions are I samples; the live input is the Q of the newest pair.
    always_comb begin
        win = {sr_q, ADC_OUT};
        i_lane = '0;
        for (int b = 0; b < 8; b++) begin
            i_lane[b] = win[2*b+1];
        end
        match = (i_lane == SYNC_WORD);
        miss_inc = miss_q + 4'd1;
    end

    always_comb begin
        state_d       = state_q;
        sr_d          = {sr_q[13:0], ADC_OUT};
        ph_d          = ~ph_q;
        pc_d          = pc_q;
        miss_d        = miss_q;
        temp_i_d      = temp_i_q;
        i_out_d       = i_out_q;
        q_out_d       = q_out_q;
        iq_valid_d    = 1'b0;
        frame_start_d = 1'b0;
        loss_d        = 1'b0;

        if (!START) begin
            // Abort wins over everything else; I/Q outputs keep their last values.
            state_d = StIdle;
            sr_d    = '0;
            ph_d    = 1'b0;
            pc_d    = '0;
            miss_d  = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    sr_d    = '0;
                    ph_d    = 1'b0;
                    pc_d    = '0;
                    miss_d  = '0;
                    state_d = StSearch;
                end
                StSearch: begin
                    ph_d = 1'b0;
                    if (match) begin
                        state_d = StPayload;
                        pc_d    = '0;
                    end
                end
                StPayload: begin
                    if (!ph_q) begin
                        temp_i_d = ADC_OUT;
                    end else begin
                        i_out_d       = temp_i_q;
                        q_out_d       = ADC_OUT;
                        iq_valid_d    = 1'b1;
                        frame_start_d = (pc_q == 8'd0);
                        if (pc_q == PcLast) begin
                            state_d = StSync;
                            pc_d    = '0;
                        end else begin
                            pc_d = pc_q + 8'd1;
                        end
                    end
                end
                StSync: begin
                    if (ph_q) begin
                        if (pc_q == 8'd7) begin
                            // Window now holds exactly the eight sync pairs.
                            pc_d = '0;
                            if (match) begin
                                miss_d  = '0;
                                state_d = StPayload;
                            end else if (miss_inc == MissLim) begin
                                loss_d  = 1'b1;
                                miss_d  = '0;
                                state_d = StSearch;
                            end else begin
                                miss_d  = miss_inc;
                                state_d = StPayload;
                            end
                        end else begin
                            pc_d = pc_q + 8'd1;
                        end
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK_1 or negedge RST) begin
        if (!RST) begin
            state_q       <= StIdle;
            sr_q          <= '0;
            ph_q          <= 1'b0;
            pc_q          <= '0;
            miss_q        <= '0;
            temp_i_q      <= 1'b0;
            i_out_q       <= 1'b0;
            q_out_q       <= 1'b0;
            iq_valid_q    <= 1'b0;
            frame_start_q <= 1'b0;
            loss_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sr_q          <= sr_d;
            ph_q          <= ph_d;
            pc_q          <= pc_d;
            miss_q        <= miss_d;
            temp_i_q      <= temp_i_d;
            i_out_q       <= i_out_d;
            q_out_q       <= q_out_d;
            iq_valid_q    <= iq_valid_d;
            frame_start_q <= frame_start_d;
            loss_q        <= loss_d;
        end
    end

    assign STATE       = state_q;
    assign LOCKED      = state_q[1];
    assign I_OUT       = i_out_q;
    assign Q_OUT       = q_out_q;
    assign IQ_VALID    = iq_valid_q;
    assign FRAME_START = frame_start_q;
    assign LOSS        = loss_q;

endmodule

// File: tb/tb_il_frame_ctrl.sv
// tb_il_frame_ctrl: directed-vector bench for il_frame_ctrl. Stimulus pushes the expected
// payload pairs into a queue; a monitor pops and compares whenever IQ_VALID is seen.
module tb_il_frame_ctrl;

    localparam int FrameLen = 32;

    logic       CLK_1;
    logic       RST;
    logic       START;
    logic       ADC_OUT;
    logic       I_OUT;
    logic       Q_OUT;
    logic       IQ_VALID;
    logic       FRAME_START;
    logic       LOCKED;
    logic       LOSS;
    logic [1:0] STATE;

    int checks;
    int failures;
    int valid_cnt;
    int loss_cnt;
    int pushed;
    logic [2:0] exp_q[$];  // {frame_start, i, q}

    il_frame_ctrl dut (
        .CLK_1      (CLK_1),
        .RST        (RST),
        .START      (START),
        .ADC_OUT    (ADC_OUT),
        .I_OUT      (I_OUT),
        .Q_OUT      (Q_OUT),
        .IQ_VALID   (IQ_VALID),
        .FRAME_START(FRAME_START),
        .LOCKED     (LOCKED),
        .LOSS       (LOSS),
        .STATE      (STATE)
    );

    initial CLK_1 = 1'b0;
    always #5 CLK_1 = ~CLK_1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: sample 1 time unit after each rising edge.
    initial begin
        logic [2:0] e;
        forever begin
            @(posedge CLK_1);
            #1;
            if (LOSS) loss_cnt++;
            if (IQ_VALID) begin
                valid_cnt++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_iq_valid", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pair_out", int'({FRAME_START, I_OUT, Q_OUT}), int'(e));
                end
            end else if (FRAME_START) begin
                chk("frame_start_without_valid", 1, 0);
            end
        end
    end

    task automatic drive(input logic b);
        ADC_OUT = b;
        @(posedge CLK_1);
        #2;
    endtask

    task automatic send_pair(input logic i, input logic q);
        drive(i);
        drive(q);
    endtask

    task automatic send_sync(input logic [7:0] word);
        for (int j = 7; j >= 0; j--) send_pair(word[j], 1'b0);
    endtask

    // Payload pair p carries I=p[0], Q=~p[0].
    task automatic send_pairs(input int n);
        logic [31:0] pv;
        for (int p = 0; p < n; p++) begin
            pv = p;
            exp_q.push_back({(p == 0), pv[0], ~pv[0]});
            pushed++;
            send_pair(pv[0], ~pv[0]);
        end
    endtask

    initial begin
        checks = 0; failures = 0; valid_cnt = 0; loss_cnt = 0; pushed = 0;
        RST = 1'b0; START = 1'b0; ADC_OUT = 1'b0;
        #12;
        // Reset state
        chk("rst_state", int'(STATE), 0);
        chk("rst_outputs", int'({IQ_VALID, FRAME_START, LOCKED, LOSS, I_OUT, Q_OUT}), 0);
        RST = 1'b1; START = 1'b1;
        drive(1'b0);
        chk("search_after_start", int'(STATE), 1);

        // Aligned sync then a frame
        send_sync(8'hE5);
        chk("lock_state", int'(STATE), 2);
        chk("locked_after_sync", int'(LOCKED), 1);
        send_pairs(FrameLen);
        chk("sync_state_after_frame", int'(STATE), 3);
        chk("valid_count_frame1", valid_cnt, FrameLen);
        send_sync(8'hE5);
        chk("good_resync", int'(STATE), 2);
        send_pairs(FrameLen);

        // Flywheel: two bad syncs, then a good one
        send_sync(8'h00);
        chk("flywheel1_locked", int'({LOCKED, STATE}), 6);
        send_pairs(FrameLen);
        send_sync(8'h00);
        chk("flywheel2_locked", int'({LOCKED, STATE}), 6);
        send_pairs(FrameLen);
        send_sync(8'hE5);
        send_pairs(FrameLen);
        chk("flywheel_no_loss", loss_cnt, 0);

        // Loss: three consecutive bad syncs (misses were cleared by the good sync)
        send_sync(8'h00);
        send_pairs(FrameLen);
        send_sync(8'h00);
        chk("miss2_no_loss", int'(LOSS), 0);
        send_pairs(FrameLen);
        send_sync(8'h00);
        chk("loss_pulse", int'(LOSS), 1);
        chk("loss_state", int'({LOCKED, STATE}), 1);
        drive(1'b0);
        chk("loss_one_cycle", int'(LOSS), 0);
        chk("loss_count", loss_cnt, 1);
        send_sync(8'hE5);
        chk("relock", int'(STATE), 2);
        send_pairs(FrameLen);

        // Abort mid-payload at a Q edge; outputs hold pair 4 (I=0, Q=1)
        send_sync(8'hE5);
        send_pairs(5);
        drive(1'b1);
        START = 1'b0;
        drive(1'b0);
        chk("abort_state", int'(STATE), 0);
        chk("abort_no_valid", int'({IQ_VALID, FRAME_START, LOCKED}), 0);
        chk("abort_hold_iq", int'({I_OUT, Q_OUT}), 1);

        // Restart with one junk bit before the sync (misaligned by one sample)
        START = 1'b1;
        drive(1'b0);
        chk("restart_search", int'(STATE), 1);
        drive(1'b1);
        send_sync(8'hE5);
        chk("misaligned_lock", int'(STATE), 2);
        send_pairs(FrameLen);

        // Reset mid-payload, asynchronously, just after a valid pair (I=1, Q=0)
        send_sync(8'hE5);
        send_pairs(2);
        chk("pre_reset_valid", int'({IQ_VALID, I_OUT, Q_OUT}), 6);
        RST = 1'b0;
        #1;
        chk("async_rst_state", int'(STATE), 0);
        chk("async_rst_outputs",
            int'({IQ_VALID, FRAME_START, LOCKED, LOSS, I_OUT, Q_OUT}), 0);
        RST = 1'b1;
        drive(1'b0);
        chk("post_rst_search", int'(STATE), 1);

        chk("total_valid", valid_cnt, pushed);
        chk("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
